mii_rx_frame_ctrl: RTL

Receive-side frame controller that sequences the byte stream produced by `MIIcore`, which delivers one byte per `rdy` pulse. It tracks preamble/SFD, parses the Ethernet header, and applies a destination-address filter. It streams payload bytes downstream with the 4-byte FCS stripped and reports per-frame status and length. It sits between `MIIcore` and the packet consumer in the `clk` domain.

---
 rtl/mii_rx_pkg.sv | 36 +++
 rtl/mii_rx_tail_delay.sv | 54 +++++
 rtl/mii_rx_frame_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mii_rx_pkg.sv
// Shared definitions for the MII receive frame controller.
//   state_t  : frame sequencing states
//   status_t : per-frame completion codes reported with done
//   PRE_BYTE, SFD_BYTE, HDR_LEN, FCS_LEN : framing constants
//   mac_byte : selects one octet of a station address, MSB-first
package mii_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    PAY,
    DROP,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_RUNT = 2'd1,
    ST_ERR  = 2'd2,
    ST_LONG = 2'd3
  } status_t;

  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam int         HDR_LEN  = 14;
  localparam int         FCS_LEN  = 4;

  // Octet idx of a 48-bit address as it appears on the wire (idx 0 = MSB).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] shifted;
    shifted = mac << (6'd8 * 6'(idx));
    return shifted[47:40];
  endfunction

endpackage

// File: rtl/mii_rx_tail_delay.sv
// Byte delay line that holds back the last DEPTH bytes of a stream.
// Once full, every push shifts the oldest byte out on pop_d with pop_valid
// asserted for one cycle (the cycle after the push).
//   clk, reset   : clock, asynchronous active-low reset
//   flush        : empty the line (takes priority over push)
//   push, din    : byte to insert
//   pop_valid    : one-cycle strobe, pop_d holds the evicted byte
//   pop_d        : evicted byte (holds its value between strobes)
//   fill         : number of bytes currently held
module mii_rx_tail_delay
  import mii_rx_pkg::*;
#(
  parameter int DEPTH = FCS_LEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [7:0]                 din,
  output logic                       pop_valid,
  output logic [7:0]                 pop_d,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int FW = $clog2(DEPTH + 1);

  logic [7:0] sr [DEPTH];

  // NOTE: the delay line is tiny and its contents must not leak across a
  // reset into the next frame, so it is reset like ordinary state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      fill      <= '0;
      pop_valid <= 1'b0;
      pop_d     <= '0;
    end else begin
      pop_valid <= 1'b0;
      if (flush) begin
        fill <= '0;
      end else if (push) begin
        sr[0] <= din;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        if (fill == FW'(DEPTH)) begin
          pop_valid <= 1'b1;
          pop_d     <= sr[DEPTH-1];
        end else begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mii_rx_frame_ctrl.sv
// Receive frame controller behind an MII byte de-serialiser.
// Tracks preamble/SFD, parses the 14-byte Ethernet header, filters on the
// destination address and streams the payload with the FCS stripped.
//   clk, reset          : clock, asynchronous active-low reset
//   in_en               : frame active (already synchronous)
//   in_rdy, in_d        : one-cycle byte strobe and byte
//   in_err              : receive error from the MII core
//   promisc             : accept any destination address
//   out_valid, out_d    : payload byte stream, FCS removed
//   eth_type            : EtherType of the current/last accepted frame
//   done, status, len   : end-of-frame report for accepted frames
//   frame_cnt, drop_cnt : saturating good-frame / dropped-frame counters
module mii_rx_frame_ctrl
  import mii_rx_pkg::*;
#(
  parameter logic [47:0] MY_MAC      = 48'h54ff01212324,
  parameter int          MAX_PAYLOAD = 1500,
  parameter int          MIN_PAYLOAD = 46
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic        in_rdy,
  input  logic [7:0]  in_d,
  input  logic        in_err,
  input  logic        promisc,
  output logic        out_valid,
  output logic [7:0]  out_d,
  output logic [15:0] eth_type,
  output logic        done,
  output logic [1:0]  status,
  output logic [10:0] len,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  // Payload bytes (FCS included) beyond which the frame is too long.
  localparam logic [10:0] LONG_LIMIT = 11'(MAX_PAYLOAD + FCS_LEN);
  localparam logic [10:0] MIN_LEN    = 11'(MIN_PAYLOAD);
  localparam logic [10:0] FCS_CNT    = 11'(FCS_LEN);

  state_t      state;
  state_t      st_b;
  status_t     err_st;
  status_t     err_b;
  logic        en_q;
  logic        en_rise;
  logic        en_fall;
  logic [3:0]  pre_cnt;
  logic [3:0]  hdr_idx;
  logic        mac_ok;
  logic        bc_ok;
  logic [10:0] pay_cnt;
  logic [10:0] pay_b;
  logic [10:0] len_b;
  logic        push;
  logic [7:0]  mac_b;
  logic        accept;

  assign en_rise = in_en & ~en_q;
  assign en_fall = ~in_en & en_q;

  // Running address comparison; the decision is taken on header byte 5
  // using the flags accumulated over bytes 0..4 plus the current byte.
  assign mac_b  = mac_byte(MY_MAC, hdr_idx[2:0]);
  assign accept = promisc | (mac_ok & (in_d == mac_b)) | (bc_ok & (in_d == 8'hFF));

  // Effect of the byte/error seen this cycle. End of frame is evaluated on
  // top of these values so a byte arriving with the in_en fall still counts.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    st_b  = state;
    err_b = err_st;
    pay_b = pay_cnt;
    push  = 1'b0;
    case (state)
      PRE: begin
        if (in_rdy) begin
          if (in_d == SFD_BYTE && pre_cnt != '0) st_b = HDR;
          else if (in_d != PRE_BYTE)             st_b = DROP;
        end
        if (in_err) begin
          st_b  = ERR;
          err_b = ST_ERR;
        end
      end
      HDR: begin
        if (in_rdy) begin
          if (hdr_idx == 4'd5 && !accept)          st_b = DROP;
          else if (hdr_idx == 4'(HDR_LEN - 1))     st_b = PAY;
        end
        if (in_err) begin
          st_b  = ERR;
          err_b = ST_ERR;
        end
      end
      PAY: begin
        if (in_rdy) begin
          push = 1'b1;
          if (pay_cnt != '1) pay_b = pay_cnt + 1'b1;
          if (pay_b > LONG_LIMIT) begin
            st_b  = ERR;
            err_b = ST_LONG;
          end
        end
        // Checked last so a receive error outranks a length violation.
        if (in_err) begin
          st_b  = ERR;
          err_b = ST_ERR;
        end
      end
      ERR: begin
        if (in_err) err_b = ST_ERR;
      end
      default: ;
    endcase
  end

  // The last FCS_LEN bytes are the FCS and never count toward len.
  assign len_b = (pay_b >= FCS_CNT) ? pay_b - FCS_CNT : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      en_q      <= 1'b1;   // a frame in flight at reset release is ignored
      err_st    <= ST_OK;
      pre_cnt   <= '0;
      hdr_idx   <= '0;
      mac_ok    <= 1'b0;
      bc_ok     <= 1'b0;
      pay_cnt   <= '0;
      eth_type  <= '0;
      done      <= 1'b0;
      status    <= ST_OK;
      len       <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      en_q    <= in_en;
      done    <= 1'b0;
      state   <= st_b;
      err_st  <= err_b;
      pay_cnt <= pay_b;

      if (state == PRE && in_rdy && in_d == PRE_BYTE && pre_cnt != '1)
        pre_cnt <= pre_cnt + 1'b1;

      if (state == HDR && in_rdy) begin
        hdr_idx <= hdr_idx + 1'b1;
        if (hdr_idx < 4'd6) begin
          mac_ok <= mac_ok & (in_d == mac_b);
          bc_ok  <= bc_ok & (in_d == 8'hFF);
        end
        if (hdr_idx == 4'd12) eth_type[15:8] <= in_d;
        if (hdr_idx == 4'd13) eth_type[7:0]  <= in_d;
      end

      if (state == IDLE && en_rise) begin
        state   <= PRE;
        err_st  <= ST_OK;
        pre_cnt <= '0;
        hdr_idx <= '0;
        mac_ok  <= 1'b1;
        bc_ok   <= 1'b1;
        pay_cnt <= '0;
      end

      if (en_fall) begin
        state <= IDLE;
        case (st_b)
          PAY: begin
            done <= 1'b1;
            len  <= len_b;
            if (len_b < MIN_LEN) begin
              status <= ST_RUNT;
            end else begin
              status <= ST_OK;
              if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
            end
          end
          ERR: begin
            done   <= 1'b1;
            len    <= len_b;
            status <= err_b;
          end
          PRE, HDR, DROP: begin
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // The delay line is emptied whenever no frame is in progress.
  mii_rx_tail_delay #(
    .DEPTH (FCS_LEN)
  ) u_tail (
    .clk       (clk),
    .reset     (reset),
    .flush     (state == IDLE),
    .push      (push),
    .din       (in_d),
    .pop_valid (out_valid),
    .pop_d     (out_d),
    .fill      ()
  );

endmodule
